player_motion_ctrl: RTL
=======================

PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 Parameter STEP_DIV, default 500000, procClock cycles per movement tick (minimum 2).
REQ-002 Parameter P0_X0 / P0_Y0, default 40 / 40, player 0 reset position.
REQ-003 Parameter P1_X0 / P1_Y0, default 576 / 416, player 1 reset position.
REQ-004 Parameter MAX_X / MAX_Y, default 616 / 456, largest legal top-left coordinate (640-24, 480-24).
REQ-005 procClock  in  1  the single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset, sampled on procClock.
REQ-007 ps2_key_pressed  in  1  one-cycle strobe: ps2_key_data_in holds a new scan-code byte.
REQ-008 ps2_key_data_in  in  8  PS/2 set-2 scan-code byte.
REQ-009 player0_collisionUp/Down/Left/Right  in  1 each  wall adjacent to player 0 in that direction.
REQ-010 player1_collisionUp/Down/Left/Right  in  1 each  wall adjacent to player 1 in that direction.
REQ-011 player0_x, player0_y, player1_x, player1_y  out  32 each  top-left sprite position; bits [31:10] of x and [31:9] of y SHALL be 0.
REQ-012 move_tick  out  1  one-cycle pulse, asserted in the cycle a movement step is applied.

Function
REQ-013 Decoder FSM states: IDLE, BRK; byte 0xE0 SHALL leave state unchanged (prefix ignored); 0xF0 SHALL go to BRK.
REQ-014 In IDLE a mapped code SHALL set its held bit; in BRK a mapped code SHALL clear its held bit; any non-prefix byte SHALL return FSM to IDLE.
REQ-015 Map: player 0 W=0x1D up, S=0x1B down, A=0x1C left, D=0x23 right; player 1 0x75 up, 0x72 down, 0x6B left, 0x74 right.
REQ-016 Unmapped non-prefix bytes SHALL change no held bit and SHALL return FSM to IDLE.
REQ-017 Held bits SHALL update on the edge that samples ps2_key_pressed=1; bytes without strobe SHALL be ignored.
REQ-018 Tick counter SHALL count 0..STEP_DIV-1 and wrap to 0; move_tick SHALL be 1 exactly while counter = STEP_DIV-1.
REQ-019 On the edge ending a move_tick cycle, each player SHALL move at most 1 pixel in one direction, priority up > down > left > right among its held bits.
REQ-020 The selected move SHALL be suppressed (no fallback to lower priority) if the matching collision input is 1 in that cycle.
REQ-021 The selected move SHALL be suppressed if it would leave 0..MAX_X (x) or 0..MAX_Y (y); no wrap-around, no underflow.
REQ-022 Players SHALL move independently; overlap of the two sprites is not blocked.
REQ-023 A key strobe in a move_tick cycle SHALL update held bits on that edge; the move SHALL use held bits as registered before that edge.
REQ-024 Position outputs SHALL be registered; new value visible in the cycle after move_tick.

Reset
REQ-025 While reset=1 on an edge: FSM to IDLE, all 8 held bits 0, tick counter 0, move_tick 0.
REQ-026 Reset values: player0_x=P0_X0, player0_y=P0_Y0, player1_x=P1_X0, player1_y=P1_Y0.
REQ-027 Reset asserted mid-BRK or mid-count SHALL discard the pending prefix and partial count; no move occurs on the reset edge.

Verification (STEP_DIV=4 unless noted)
REQ-028 Reset, no keys, 20 cycles -> outputs stay 40/40/576/416; move_tick pulses at cycles 3,7,11,... after reset release.
REQ-029 Strobe 0x23 (D), wait 3 ticks, strobe 0xF0 then 0x23 -> player0_x 40->43 then holds; player0_y unchanged.
REQ-030 Hold W and A for player 0 -> only y decrements per tick; assert player0_collisionUp -> y holds and x does not change.
REQ-031 P1_X0=615, hold 0x74 -> player1_x 615->616 then holds at 616 for further ticks; P0_Y0=0, hold W -> y stays 0.
REQ-032 Strobe 0xE0,0x75 then 0xE0,0xF0,0x75; also 0xF0,0x55 -> player1 moves up while held, stops after release; 0x55 changes nothing, FSM back in IDLE.
REQ-033 Strobe 0xF0, assert reset one cycle, then strobe 0x1D -> W treated as press (held bit set), positions back to reset values.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// rtl/player_motion_ctrl.sv - PS/2 key decoder driving two rate-limited, wall- and edge-bounded sprite positions
module player_motion_ctrl #(
    parameter int STEP_DIV = 500000,
    parameter int P0_X0    = 40,
    parameter int P0_Y0    = 40,
    parameter int P1_X0    = 576,
    parameter int P1_Y0    = 416,
    parameter int MAX_X    = 616,
    parameter int MAX_Y    = 456
) (
    input  logic        procClock,
    input  logic        reset,
    input  logic        ps2_key_pressed,
    input  logic [7:0]  ps2_key_data_in,
    input  logic        player0_collisionUp,
    input  logic        player0_collisionDown,
    input  logic        player0_collisionLeft,
    input  logic        player0_collisionRight,
    input  logic        player1_collisionUp,
    input  logic        player1_collisionDown,
    input  logic        player1_collisionLeft,
    input  logic        player1_collisionRight,
    output logic [31:0] player0_x,
    output logic [31:0] player0_y,
    output logic [31:0] player1_x,
    output logic [31:0] player1_y,
    output logic        move_tick
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BRK  = 1'b1;
    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    // held[3:0] = player 0 {right,left,down,up}, held[7:4] = player 1 same order
    logic [7:0]    held;
    logic [9:0]    p0_x, p1_x;
    logic [8:0]    p0_y, p1_y;
    logic [18:0]   p0_next, p1_next;
    logic          make;

    // One step with fixed priority up > down > left > right; a blocked choice
    // is dropped rather than falling through to the next held direction.
    function automatic logic [18:0] step(input logic [9:0] x, input logic [8:0] y,
                                         input logic [3:0] k, input logic [3:0] c);
        logic [9:0] nx;
        logic [8:0] ny;
        nx = x;
        ny = y;
        if (k[0]) begin
            if (!c[0] && y != 9'd0) ny = y - 9'd1;
        end else if (k[1]) begin
            if (!c[1] && y < 9'(MAX_Y)) ny = y + 9'd1;
        end else if (k[2]) begin
            if (!c[2] && x != 10'd0) nx = x - 10'd1;
        end else if (k[3]) begin
            if (!c[3] && x < 10'(MAX_X)) nx = x + 10'd1;
        end
        return {nx, ny};
    endfunction

    assign move_tick = (cnt == LAST);
    assign make      = (state == IDLE);

    always_comb begin
        p0_next = step(p0_x, p0_y, held[3:0],
                       {player0_collisionRight, player0_collisionLeft,
                        player0_collisionDown, player0_collisionUp});
        p1_next = step(p1_x, p1_y, held[7:4],
                       {player1_collisionRight, player1_collisionLeft,
                        player1_collisionDown, player1_collisionUp});
    end

    always_ff @(posedge procClock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= '0;
            p0_x  <= 10'(P0_X0);
            p0_y  <= 9'(P0_Y0);
            p1_x  <= 10'(P1_X0);
            p1_y  <= 9'(P1_Y0);
        end else begin
            cnt <= move_tick ? '0 : cnt + CW'(1);
            if (ps2_key_pressed) begin
                if (ps2_key_data_in == 8'hF0) begin
                    state <= BRK;
                end else if (ps2_key_data_in != 8'hE0) begin
                    state <= IDLE;
                    case (ps2_key_data_in)
                        8'h1D:   held[0] <= make;
                        8'h1B:   held[1] <= make;
                        8'h1C:   held[2] <= make;
                        8'h23:   held[3] <= make;
                        8'h75:   held[4] <= make;
                        8'h72:   held[5] <= make;
                        8'h6B:   held[6] <= make;
                        8'h74:   held[7] <= make;
                        default: ;
                    endcase
                end
            end
            if (move_tick) begin
                {p0_x, p0_y} <= p0_next;
                {p1_x, p1_y} <= p1_next;
            end
        end
    end

    assign player0_x = {22'd0, p0_x};
    assign player0_y = {23'd0, p0_y};
    assign player1_x = {22'd0, p1_x};
    assign player1_y = {23'd0, p1_y};

endmodule
